// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared FSM states, opcodes, ALU/operand-B encodings and the control bundle
package ctrl_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_ADDR, S_MEM_RD, S_MEM_WR, S_WB, S_BRANCH, S_JUMP, S_HALT
  } state_t;
  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_ORI   = 4'h2;
  localparam logic [3:0] OP_LW    = 4'h4;
  localparam logic [3:0] OP_SW    = 4'h5;
  localparam logic [3:0] OP_BEQ   = 4'h8;
  localparam logic [3:0] OP_BNE   = 4'h9;
  localparam logic [3:0] OP_JMP   = 4'hA;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b11;
  localparam logic [2:0] SRCB_TWO  = 3'b000;
  localparam logic [2:0] SRCB_REG  = 3'b001;
  localparam logic [2:0] SRCB_IMM  = 3'b010;
  localparam logic [2:0] SRCB_ZIMM = 3'b011;
  localparam logic [2:0] SRCB_JMP  = 3'b101;
  typedef struct packed {
    logic       pc_wr;
    logic [1:0] regA;
    logic       regB;
    logic       reg_dst;
    logic       read3;
    logic       reg_wr;
    logic       alu_srcA;
    logic [2:0] alu_srcB;
    logic [1:0] alu_op;
    logic       output_cont;
    logic       pc_src;
    logic       mem_to_reg;
    logic       eqb;
    logic       memr;
    logic       memw;
    logic       halted;
    logic       illegal;
  } ctrl_t;
  function automatic logic op_known(input logic [3:0] op);
    return op inside {OP_RTYPE, OP_ADDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_JMP};
  endfunction
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: per-state datapath control decode (i_state, i_op, i_fn in; o_ctrl bundle out)
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter logic [3:0] HALT_OP = 4'hF
) (
  input  state_t     i_state,
  input  logic [3:0] i_op,
  input  logic [3:0] i_fn,
  output ctrl_t      o_ctrl
);
  logic w_unused;
  assign w_unused = i_fn[2];
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: o_ctrl.pc_wr = 1'b1;
      S_DECODE: begin
        o_ctrl.regA  = (i_op == OP_LW || i_op == OP_SW) ? 2'b10 : (i_op == OP_ADDI || i_op == OP_ORI) ? 2'b01 : 2'b00;
        o_ctrl.regB  = i_op == OP_SW;
        o_ctrl.read3 = i_op == OP_BEQ || i_op == OP_BNE;
      end
      S_EXEC: begin
        o_ctrl.alu_srcA    = 1'b1;
        o_ctrl.alu_srcB    = i_op == OP_ADDI ? SRCB_IMM : i_op == OP_ORI ? SRCB_ZIMM : SRCB_REG;
        o_ctrl.alu_op      = i_op == OP_ORI ? ALU_OR : (i_op == OP_RTYPE && !i_fn[3]) ? i_fn[1:0] : ALU_ADD;
        o_ctrl.output_cont = i_op == OP_RTYPE && i_fn[3];
      end
      S_ADDR: begin
        o_ctrl.alu_srcA = 1'b1;
        o_ctrl.alu_srcB = SRCB_IMM;
      end
      S_MEM_RD: o_ctrl.memr = 1'b1;
      S_MEM_WR: o_ctrl.memw = 1'b1;
      S_WB: begin
        o_ctrl.reg_wr     = 1'b1;
        o_ctrl.mem_to_reg = i_op == OP_LW;
        o_ctrl.reg_dst    = i_op == OP_LW;
      end
      S_BRANCH: begin
        o_ctrl.alu_srcA = 1'b1;
        o_ctrl.alu_srcB = SRCB_REG;
        o_ctrl.alu_op   = ALU_SUB;
        o_ctrl.pc_src   = 1'b1;
        o_ctrl.eqb      = i_op == OP_BNE;
      end
      S_JUMP: begin
        o_ctrl.pc_wr    = 1'b1;
        o_ctrl.alu_srcB = SRCB_JMP;
      end
      S_HALT: begin
        o_ctrl.halted  = 1'b1;
        o_ctrl.illegal = i_op != HALT_OP && !op_known(i_op);
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: multicycle CPU control FSM (clk, rst_n, start, ir in; datapath controls, halted/illegal, instr_cnt out)
module control_unit
  import ctrl_pkg::*;
#(
  parameter logic [3:0] HALT_OP = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] ir,
  output logic        pc_wr,
  output logic        regB,
  output logic        reg_dst,
  output logic        read3,
  output logic        reg_wr,
  output logic        alu_srcA,
  output logic        output_cont,
  output logic        pc_src,
  output logic        mem_to_reg,
  output logic        eqb,
  output logic        instr_wr,
  output logic        memr,
  output logic        memw,
  output logic [1:0]  regA,
  output logic [1:0]  alu_op,
  output logic [2:0]  alu_srcB,
  output logic        halted,
  output logic        illegal,
  output logic [15:0] instr_cnt
);
  state_t      r_state, w_next;
  logic [3:0]  r_op_q, r_fn_q, w_op, w_fn;
  logic [15:0] r_instr_cnt;
  logic        w_last, w_unused;
  ctrl_t       w_ctrl;
  // DECODE sees the live instruction; later states use the copy latched at DECODE's closing edge
  assign w_op     = r_state == S_DECODE ? ir[15:12] : r_op_q;
  assign w_fn     = r_state == S_DECODE ? ir[3:0] : r_fn_q;
  assign w_last   = r_state inside {S_MEM_WR, S_WB, S_BRANCH, S_JUMP};
  assign w_unused = ^ir[11:4];
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = start ? S_FETCH : S_IDLE;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = (w_op == HALT_OP || !op_known(w_op)) ? S_HALT :
                         (w_op inside {OP_RTYPE, OP_ADDI, OP_ORI}) ? S_EXEC :
                         (w_op inside {OP_LW, OP_SW}) ? S_ADDR :
                         w_op == OP_JMP ? S_JUMP : S_BRANCH;
      S_EXEC:   w_next = S_WB;
      S_ADDR:   w_next = w_op == OP_LW ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: w_next = S_WB;
      S_MEM_WR, S_WB, S_BRANCH, S_JUMP: w_next = S_FETCH;
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op_q      <= '0;
      r_fn_q      <= '0;
      r_instr_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_op_q <= ir[15:12];
        r_fn_q <= ir[3:0];
      end
      if (w_last) r_instr_cnt <= r_instr_cnt + 16'd1;
    end
  end
  ctrl_decode #(.HALT_OP(HALT_OP)) u_dec (
    .i_state(r_state),
    .i_op   (w_op),
    .i_fn   (w_fn),
    .o_ctrl (w_ctrl)
  );
  assign pc_wr       = w_ctrl.pc_wr;
  assign regA        = w_ctrl.regA;
  assign regB        = w_ctrl.regB;
  assign reg_dst     = w_ctrl.reg_dst;
  assign read3       = w_ctrl.read3;
  assign reg_wr      = w_ctrl.reg_wr;
  assign alu_srcA    = w_ctrl.alu_srcA;
  assign alu_srcB    = w_ctrl.alu_srcB;
  assign alu_op      = w_ctrl.alu_op;
  assign output_cont = w_ctrl.output_cont;
  assign pc_src      = w_ctrl.pc_src;
  assign mem_to_reg  = w_ctrl.mem_to_reg;
  assign eqb         = w_ctrl.eqb;
  assign memr        = w_ctrl.memr;
  assign memw        = w_ctrl.memw;
  assign halted      = w_ctrl.halted;
  assign illegal     = w_ctrl.illegal;
  assign instr_wr    = 1'b0;
  assign instr_cnt   = r_instr_cnt;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: table-driven, hand-sequence and randomized model checks of control_unit
module tb_control_unit;
  typedef struct packed {
    logic       pc_wr;
    logic [1:0] regA;
    logic       regB;
    logic       reg_dst;
    logic       read3;
    logic       reg_wr;
    logic       alu_srcA;
    logic [2:0] alu_srcB;
    logic [1:0] alu_op;
    logic       output_cont;
    logic       pc_src;
    logic       mem_to_reg;
    logic       eqb;
    logic       instr_wr;
    logic       memr;
    logic       memw;
    logic       halted;
    logic       illegal;
  } ctl_t;
  typedef struct {
    logic [15:0] ir;
    int          lat;
    logic [1:0]  regA;
    logic [2:0]  srcB;
    logic [1:0]  aop;
  } vec_t;
  logic clk, rst_n, start;
  logic [15:0] ir, instr_cnt;
  logic pc_wr, regB, reg_dst, read3, reg_wr, alu_srcA, output_cont, pc_src, mem_to_reg, eqb, instr_wr, memr, memw;
  logic [1:0] regA, alu_op;
  logic [2:0] alu_srcB;
  logic halted, illegal;
  ctl_t act;
  int errors = 0, checks = 0;
  logic [15:0] exp_cnt;
  ctl_t exp_q[$];
  vec_t tbl[10];
  control_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ir(ir),
    .pc_wr(pc_wr), .regB(regB), .reg_dst(reg_dst), .read3(read3), .reg_wr(reg_wr),
    .alu_srcA(alu_srcA), .output_cont(output_cont), .pc_src(pc_src), .mem_to_reg(mem_to_reg),
    .eqb(eqb), .instr_wr(instr_wr), .memr(memr), .memw(memw), .regA(regA), .alu_op(alu_op),
    .alu_srcB(alu_srcB), .halted(halted), .illegal(illegal), .instr_cnt(instr_cnt)
  );
  assign act = {pc_wr, regA, regB, reg_dst, read3, reg_wr, alu_srcA, alu_srcB, alu_op,
                output_cont, pc_src, mem_to_reg, eqb, instr_wr, memr, memw, halted, illegal};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  // Expected per-cycle controls for one instruction, straight from the opcode's micro-step list
  function automatic void build_seq(input logic [15:0] i);
    logic [3:0] op, fn;
    ctl_t c;
    op = i[15:12];
    fn = i[3:0];
    exp_q.delete();
    c = '0; c.pc_wr = 1'b1; exp_q.push_back(c);
    c = '0;
    c.regA  = (op == 4'h4 || op == 4'h5) ? 2'b10 : (op == 4'h1 || op == 4'h2) ? 2'b01 : 2'b00;
    c.regB  = op == 4'h5;
    c.read3 = op == 4'h8 || op == 4'h9;
    exp_q.push_back(c);
    if (op <= 4'h2) begin
      c = '0;
      c.alu_srcA = 1'b1;
      c.alu_srcB = op == 4'h0 ? 3'b001 : op == 4'h1 ? 3'b010 : 3'b011;
      c.alu_op = op == 4'h2 ? 2'b11 : (op == 4'h0 && !fn[3]) ? fn[1:0] : 2'b00;
      c.output_cont = op == 4'h0 && fn[3];
      exp_q.push_back(c);
      c = '0; c.reg_wr = 1'b1; exp_q.push_back(c);
    end else if (op == 4'h4 || op == 4'h5) begin
      c = '0; c.alu_srcA = 1'b1; c.alu_srcB = 3'b010; exp_q.push_back(c);
      if (op == 4'h4) begin
        c = '0; c.memr = 1'b1; exp_q.push_back(c);
        c = '0; c.reg_wr = 1'b1; c.mem_to_reg = 1'b1; c.reg_dst = 1'b1; exp_q.push_back(c);
      end else begin
        c = '0; c.memw = 1'b1; exp_q.push_back(c);
      end
    end else if (op == 4'h8 || op == 4'h9) begin
      c = '0; c.alu_srcA = 1'b1; c.alu_srcB = 3'b001; c.alu_op = 2'b01; c.pc_src = 1'b1; c.eqb = op == 4'h9;
      exp_q.push_back(c);
    end else begin
      c = '0; c.pc_wr = 1'b1; c.alu_srcB = 3'b101; exp_q.push_back(c);
    end
  endfunction
  // Precondition: DUT sitting in FETCH; leaves it in the next FETCH
  task automatic run_model(input logic [15:0] i);
    ir = i;
    build_seq(i);
    foreach (exp_q[k]) begin
      chk($sformatf("ctl ir=%h step%0d", i, k), 32'(act), 32'(exp_q[k]));
      chk($sformatf("cnt ir=%h step%0d", i, k), 32'(instr_cnt), 32'(exp_cnt));
      tick();
    end
    exp_cnt = exp_cnt + 16'd1;
  endtask
  initial begin
    logic [3:0] pool[8];
    ctl_t h;
    int n;
    bit found;
    pool = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA};
    tbl[0] = '{16'h0123, 4, 2'b00, 3'b001, 2'b11};
    tbl[1] = '{16'h0009, 4, 2'b00, 3'b001, 2'b00};
    tbl[2] = '{16'h0002, 4, 2'b00, 3'b001, 2'b10};
    tbl[3] = '{16'h1234, 4, 2'b01, 3'b010, 2'b00};
    tbl[4] = '{16'h2345, 4, 2'b01, 3'b011, 2'b11};
    tbl[5] = '{16'h4C05, 5, 2'b10, 3'b010, 2'b00};
    tbl[6] = '{16'h5D10, 4, 2'b10, 3'b010, 2'b00};
    tbl[7] = '{16'h8123, 3, 2'b00, 3'b001, 2'b01};
    tbl[8] = '{16'h9A12, 3, 2'b00, 3'b001, 2'b01};
    tbl[9] = '{16'hA000, 3, 2'b00, 3'b101, 2'b00};
    rst_n = 1'b0; start = 1'b0; ir = 16'h0000; exp_cnt = 16'h0000;
    repeat (3) tick();
    chk("reset ctl", 32'(act), 32'h0);
    chk("reset cnt", 32'(instr_cnt), 32'h0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle hold ctl", 32'(act), 32'h0);
    pulse_start();
    run_model(16'h0123);
    chk("rtype cnt", 32'(instr_cnt), 32'h1);
    foreach (tbl[t]) begin
      ir = tbl[t].ir;
      tick();
      chk($sformatf("tbl%0d regA", t), 32'(regA), 32'(tbl[t].regA));
      tick();
      chk($sformatf("tbl%0d srcB", t), 32'(alu_srcB), 32'(tbl[t].srcB));
      chk($sformatf("tbl%0d alu_op", t), 32'(alu_op), 32'(tbl[t].aop));
      n = 3;
      found = 1'b0;
      for (int w = 0; w < 10 && !found; w++) begin
        tick();
        if (pc_wr && alu_srcB == 3'b000) found = 1'b1;
        else n++;
      end
      chk($sformatf("tbl%0d latency", t), 32'(found ? n : 0), 32'(tbl[t].lat));
      exp_cnt = exp_cnt + 16'd1;
      chk($sformatf("tbl%0d cnt", t), 32'(instr_cnt), 32'(exp_cnt));
    end
    for (int r = 0; r < 150; r++) run_model({pool[$urandom_range(0, 7)], 12'($urandom)});
    ir = 16'h5D10;
    repeat (3) tick();
    chk("sw memw", 32'(memw), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async rst memw", 32'(memw), 32'h0);
    chk("async rst ctl", 32'(act), 32'h0);
    chk("async rst cnt", 32'(instr_cnt), 32'h0);
    exp_cnt = 16'h0000;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post rst idle", 32'(act), 32'h0);
    pulse_start();
    ir = 16'h3000;
    repeat (2) tick();
    h = '0; h.halted = 1'b1; h.illegal = 1'b1;
    chk("illegal halt", 32'(act), 32'(h));
    pulse_start();
    repeat (3) tick();
    chk("illegal sticky", 32'(act), 32'(h));
    chk("illegal cnt", 32'(instr_cnt), 32'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    ir = 16'hF123;
    repeat (2) tick();
    h = '0; h.halted = 1'b1;
    chk("halt op", 32'(act), 32'(h));
    pulse_start();
    tick();
    chk("halt ignores start", 32'(act), 32'(h));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    force dut.r_instr_cnt = 16'hFFFE;
    tick();
    release dut.r_instr_cnt;
    tick();
    chk("preload cnt", 32'(instr_cnt), 32'h0000FFFE);
    exp_cnt = 16'hFFFE;
    pulse_start();
    run_model(16'hA000);
    chk("cnt ffff", 32'(instr_cnt), 32'h0000FFFF);
    run_model(16'hA000);
    chk("cnt wrap", 32'(instr_cnt), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
